// File: rtl/median_bubble_sorter_pkg.sv
// Shared types and defaults for the median sort engine.
// Optional feature switch: MEDIAN_SORT_EARLY_EXIT_EN (see median_bubble_sorter.sv).
package median_bubble_sorter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_WINDOW_SIZE = 9;

endpackage

// File: rtl/median_bubble_sorter_cmp_swap.sv
// Unsigned compare-exchange cell: lo/hi ordered, swapped flags a>b.
module median_cmp_swap #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  swapped
);

  // Strict compare keeps equal values in place, so the sort is stable.
  assign swapped = (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/median_bubble_sorter.sv
// Odd-even transposition sorter emitting the median of a loaded window.
// Define MEDIAN_SORT_EARLY_EXIT_EN to end SORT after two swap-free phases.
module median_bubble_sorter
  import median_bubble_sorter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_en,
  input  logic [3:0]            load_idx,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] median_out,
  output logic                  median_valid
);

  localparam int         NPAIR      = WINDOW_SIZE - 1;
  localparam int         MID        = WINDOW_SIZE / 2;
  localparam logic [4:0] WS5        = 5'(WINDOW_SIZE);
  localparam logic [3:0] LAST_PHASE = 4'(WINDOW_SIZE - 1);

  logic [WINDOW_SIZE-1:0][DATA_WIDTH-1:0] slot_q, slot_d;
  logic [NPAIR-1:0][DATA_WIDTH-1:0]       lo, hi;
  logic [NPAIR-1:0]                       sw;

  state_e                state_q;
  logic [3:0]            phase_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] med_q;
  logic                  vld_q;
  logic                  any_swap;
  logic                  sort_end;

  for (genvar g = 0; g < NPAIR; g++) begin : g_cmp
    median_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .a      (slot_q[g]),
      .b      (slot_q[g+1]),
      .lo     (lo[g]),
      .hi     (hi[g]),
      .swapped(sw[g])
    );
  end

  // Slot next-state: loads only in IDLE, pair exchange only in SORT.
  always_comb begin
    slot_d   = slot_q;
    any_swap = 1'b0;
    if (state_q == ST_IDLE) begin
      if (load_en && ({1'b0, load_idx} < WS5))
        slot_d[load_idx] = load_data;
    end else if (state_q == ST_SORT) begin
      for (int i = 0; i < NPAIR; i++) begin
        if (i[0] == phase_q[0]) begin
          slot_d[i]   = lo[i];
          slot_d[i+1] = hi[i];
          any_swap    = any_swap | sw[i];
        end
      end
    end
  end

`ifdef MEDIAN_SORT_EARLY_EXIT_EN
  logic zero_q;

  // zero_q remembers that the previous phase made no exchange.
  always_ff @(posedge CLK) begin
    if (RST)                     zero_q <= 1'b0;
    else if (state_q == ST_SORT) zero_q <= ~any_swap;
    else                         zero_q <= 1'b0;
  end

  assign sort_end = (phase_q == LAST_PHASE) || (~any_swap && zero_q);
`else
  logic unused_any_swap;
  assign unused_any_swap = any_swap;
  assign sort_end        = (phase_q == LAST_PHASE);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      med_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      vld_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SORT;
            phase_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SORT: begin
          phase_q <= phase_q + 4'd1;
          if (sort_end) state_q <= ST_DONE;
        end
        ST_DONE: begin
          med_q   <= slot_q[MID];
          vld_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign median_out   = med_q;
  assign median_valid = vld_q;

endmodule

// File: tb/tb_median_bubble_sorter.sv
// Scoreboard bench: stimulus pushes expected medians from a sort-based model, monitor pops on median_valid.
module tb_median_bubble_sorter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       load_en;
  logic [3:0] load_idx;
  logic [7:0] load_data;
  logic       start;
  logic       busy;
  logic [7:0] median_out;
  logic       median_valid;

  median_bubble_sorter dut (
    .CLK(CLK), .RST(RST), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .start(start), .busy(busy),
    .median_out(median_out), .median_valid(median_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int med;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   idle_at = 0;
  int   busy_run = 0;
  int   last_med = 0;
  logic [7:0] win [9];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: median = middle element of the numerically sorted window.
  function automatic int median_of();
    int v[$];
    for (int i = 0; i < 9; i++) v.push_back(int'(win[i]));
    v.sort();
    return v[4];
  endfunction

  // Drive one cycle; the model follows only what an idle engine would accept.
  task automatic drive(input logic le, input logic [3:0] idx, input logic [7:0] d, input logic st);
    exp_t e;
    load_en = le; load_idx = idx; load_data = d; start = st;
    if (cyc + 1 >= idle_at) begin
      if (le && idx < 4'd9) win[idx] = d;
      if (st) begin
        e.med = median_of();
        e.cyc = cyc + 11;
        q.push_back(e);
        idle_at = cyc + 12;
      end
    end
    @(posedge CLK); #1;
    load_en = 1'b0; start = 1'b0;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 9; i++) win[i] = 8'd0;
    idle_at = 0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_median_out", int'(median_out), 0);
    chk("reset_median_valid", int'(median_valid), 0);
  endtask

  task automatic load_window(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    int v[9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 9; i++) drive(1'b1, 4'(i), 8'(v[i]), 1'b0);
  endtask

  // Monitor: decoupled from stimulus, checks value, latency, busy width and hold.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      q.delete();
      busy_run = 0;
      last_med = 0;
    end else begin
      if (busy) busy_run++;
      if (median_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("median_value", int'(median_out), e.med);
`ifndef MEDIAN_SORT_EARLY_EXIT_EN
          chk("valid_latency", cyc, e.cyc);
          chk("busy_cycles", busy_run, 10);
`endif
        end
        busy_run = 0;
        last_med = int'(median_out);
      end else begin
        chk("median_hold", int'(median_out), last_med);
      end
    end
  end

  initial begin
    int n;
    RST = 1'b1; load_en = 1'b0; load_idx = '0; load_data = '0; start = 1'b0;
    @(posedge CLK); #1;
    do_reset();

    // Descending window -> 5.
    load_window(9, 8, 7, 6, 5, 4, 3, 2, 1);
    drive(1'b0, 4'd0, 8'd0, 1'b1);
    idle_n(11);

    // Mixed window including extremes and duplicates -> 90.
    load_window(200, 10, 255, 0, 128, 128, 7, 90, 64);
    drive(1'b0, 4'd0, 8'd0, 1'b1);
    idle_n(11);

    // All equal -> 42; then a load and a second start during SORT are ignored.
    load_window(42, 42, 42, 42, 42, 42, 42, 42, 42);
    drive(1'b0, 4'd0, 8'd0, 1'b1);
    drive(1'b1, 4'd4, 8'd99, 1'b1);
    idle_n(11);
    drive(1'b1, 4'd12, 8'd0, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b1);
    idle_n(11);

    // Reset mid-sort wipes slots; a fresh sort then yields 0.
    load_window(9, 9, 9, 9, 9, 9, 9, 9, 9);
    drive(1'b0, 4'd0, 8'd0, 1'b1);
    idle_n(3);
    do_reset();
    drive(1'b0, 4'd0, 8'd0, 1'b1);
    idle_n(11);

    // Random windows; last load sometimes shares the cycle with start.
    for (int w = 0; w < 30; w++) begin
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b1, 4'($urandom_range(9, 15)), 8'($urandom), 1'b0);
        if (i == 8 && $urandom_range(0, 1) == 1)
          drive(1'b1, 4'(i), 8'($urandom), 1'b1);
        else begin
          drive(1'b1, 4'(i), 8'($urandom), 1'b0);
          if (i == 8) drive(1'b0, 4'd0, 8'd0, 1'b1);
        end
      end
      idle_n(11 + $urandom_range(0, 2));
    end

    n = 0;
    while (q.size() != 0 && n < 50) begin
      idle_n(1);
      n++;
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
